instruction_fetcher: RTL and testbench

- Front-end stage directly upstream of the branch predictor and the instruction queue.
- Holds the architectural fetch PC and issues one 32-bit fetch request at a time to the instruction cache.
- Predecodes each returned word, presents its PC to the predictor, and chooses the next PC.
- Pushes {inst, pc, predicted-taken} into the instruction queue; a ROB flush redirects it.

---
 rtl/instruction_fetcher.sv | 107 ++++++++++
 tb/tb_instruction_fetcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: single-outstanding fetch stage with predecode and next-PC selection
// Ports: clk/rst/rdy control; flush + rob_redirect_pc restart fetch; fet_icache_* / icache_fet_*
// form the one-request cache handshake; fet_pc/bp_pred query the predictor; fet_iq_* push into
// the instruction queue when iq_full is low.
module instruction_fetcher #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic [XLEN-1:0] rob_redirect_pc,
  output logic            fet_icache_req,
  output logic [XLEN-1:0] fet_icache_addr,
  input  logic            icache_fet_valid,
  input  logic [31:0]     icache_fet_inst,
  output logic [XLEN-1:0] fet_pc,
  input  logic            bp_pred,
  input  logic            iq_full,
  output logic            fet_iq_valid,
  output logic [31:0]     fet_iq_inst,
  output logic [XLEN-1:0] fet_iq_pc,
  output logic            fet_iq_pred
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t          r_state;
  logic [XLEN-1:0] r_pc, r_h_npc;
  logic [31:0]     r_h_inst;
  logic            r_h_pred, r_drop;
  logic [XLEN-1:0] w_imm_j, w_imm_b, w_npc;
  logic            w_jal, w_br, w_pred;
  assign w_imm_j = {{(XLEN-20){icache_fet_inst[31]}}, icache_fet_inst[19:12], icache_fet_inst[20],
                    icache_fet_inst[30:21], 1'b0};
  assign w_imm_b = {{(XLEN-12){icache_fet_inst[31]}}, icache_fet_inst[7], icache_fet_inst[30:25],
                    icache_fet_inst[11:8], 1'b0};
  assign w_jal  = icache_fet_inst[6:0] == 7'b1101111;
  assign w_br   = icache_fet_inst[6:0] == 7'b1100011;
  assign w_pred = w_jal | (w_br & bp_pred);
  assign w_npc  = r_pc + (w_jal ? w_imm_j : (w_br & bp_pred) ? w_imm_b : XLEN'(4));
  assign fet_pc          = r_pc;
  assign fet_icache_addr = r_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_pc           <= RESET_PC;
      r_drop         <= 1'b0;
      r_h_inst       <= '0;
      r_h_pred       <= 1'b0;
      r_h_npc        <= '0;
      fet_icache_req <= 1'b0;
      fet_iq_valid   <= 1'b0;
      fet_iq_inst    <= '0;
      fet_iq_pc      <= '0;
      fet_iq_pred    <= 1'b0;
    end else if (rdy) begin
      fet_iq_valid <= 1'b0;
      if (flush) begin
        r_pc           <= rob_redirect_pc;
        fet_icache_req <= 1'b0;
        r_state        <= IDLE;
        // a request still in the cache must have its response swallowed later
        r_drop         <= (r_state == WAIT || r_drop) && !icache_fet_valid;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_drop) begin
              if (icache_fet_valid) r_drop <= 1'b0;
            end else if (!iq_full) begin
              fet_icache_req <= 1'b1;
              r_state        <= WAIT;
            end
          end
          WAIT: begin
            if (icache_fet_valid) begin
              fet_icache_req <= 1'b0;
              if (!iq_full) begin
                fet_iq_valid <= 1'b1;
                fet_iq_inst  <= icache_fet_inst;
                fet_iq_pc    <= r_pc;
                fet_iq_pred  <= w_pred;
                r_pc         <= w_npc;
                r_state      <= IDLE;
              end else begin
                r_h_inst <= icache_fet_inst;
                r_h_pred <= w_pred;
                r_h_npc  <= w_npc;
                r_state  <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!iq_full) begin
              fet_iq_valid <= 1'b1;
              fet_iq_inst  <= r_h_inst;
              fet_iq_pc    <= r_pc;
              fet_iq_pred  <= r_h_pred;
              r_pc         <= r_h_npc;
              r_state      <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed stimulus with a transaction-level fetch model and per-cycle compare
module tb_instruction_fetcher;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0, ivalid = 1'b0, bp_pred = 1'b0, iq_full = 1'b0;
  logic [31:0] redirect = '0, iinst = '0;
  logic req, iq_valid, iq_pred;
  logic [31:0] addr, fpc, iq_inst, iq_pc;
  int checks = 0, errors = 0;

  instruction_fetcher #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rob_redirect_pc(redirect),
    .fet_icache_req(req), .fet_icache_addr(addr), .icache_fet_valid(ivalid),
    .icache_fet_inst(iinst), .fet_pc(fpc), .bp_pred(bp_pred), .iq_full(iq_full),
    .fet_iq_valid(iq_valid), .fet_iq_inst(iq_inst), .fet_iq_pc(iq_pc), .fet_iq_pred(iq_pred)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [logic [31:0]];
  logic busy = 1'b0;
  int cnt = 0;
  logic [31:0] raddr = '0;

  typedef struct {logic [31:0] inst; logic [31:0] pc; logic [31:0] npc; logic pred;} push_t;
  push_t pend[$];
  logic [31:0] mpc = '0;
  logic mdrop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'h00000013;
  endfunction

  // expected push built from the ISA immediate definitions with plain integer arithmetic
  function automatic push_t pdec(input logic [31:0] ins, input logic [31:0] pc, input logic bp);
    push_t r;
    int ij, ib;
    ij = (ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12) + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
    ib = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
    r.inst = ins;
    r.pc = pc;
    if (ins[6:0] == 7'b1101111) begin r.pred = 1'b1; r.npc = 32'(int'(pc) + ij); end
    else if (ins[6:0] == 7'b1100011 && bp) begin r.pred = 1'b1; r.npc = 32'(int'(pc) + ib); end
    else begin r.pred = 1'b0; r.npc = pc + 32'd4; end
    return r;
  endfunction

  // one cycle: the cache model answers a request two cycles after seeing it, pausing with rdy
  task automatic cyc();
    @(negedge clk);
    if (rst) begin
      busy = 1'b0;
      ivalid = 1'b0;
    end else if (rdy) begin
      ivalid = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin busy = 1'b0; ivalid = 1'b1; iinst = rd(raddr); end
      end else if (req) begin
        busy = 1'b1;
        cnt = 2;
        raddr = addr;
      end
    end
  endtask

  initial begin
    push_t e;
    logic ep;
    logic s_req, s_v, s_pred;
    logic [31:0] s_pc, s_inst, s_ipc;
    s_req = 0; s_v = 0; s_pred = 0; s_pc = 0; s_inst = 0; s_ipc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend.delete();
        mpc = 32'h0;
        mdrop = 1'b0;
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_iq_valid", {31'b0, iq_valid}, 0);
        chk("rst_iq_inst", iq_inst, 0);
        chk("rst_iq_pc", iq_pc, 0);
        chk("rst_iq_pred", {31'b0, iq_pred}, 0);
        chk("rst_fet_pc", fpc, 32'h0);
      end else if (!rdy) begin
        chk("frozen_req", {31'b0, req}, {31'b0, s_req});
        chk("frozen_iq_valid", {31'b0, iq_valid}, {31'b0, s_v});
        chk("frozen_pc", fpc, s_pc);
        chk("frozen_iq_inst", iq_inst, s_inst);
        chk("frozen_iq_pc", iq_pc, s_ipc);
        chk("frozen_iq_pred", {31'b0, iq_pred}, {31'b0, s_pred});
      end else begin
        if (ivalid && !flush) begin
          if (mdrop) mdrop = 1'b0;
          else pend.push_back(pdec(iinst, mpc, bp_pred));
        end
        if (flush) begin
          pend.delete();
          mpc = redirect;
          mdrop = busy;
        end
        ep = !flush && !iq_full && pend.size() > 0;
        chk("model_push_valid", {31'b0, iq_valid}, {31'b0, ep});
        if (ep) begin
          e = pend.pop_front();
          chk("model_push_inst", iq_inst, e.inst);
          chk("model_push_pc", iq_pc, e.pc);
          chk("model_push_pred", {31'b0, iq_pred}, {31'b0, e.pred});
          mpc = e.npc;
        end
        chk("model_fet_pc", fpc, mpc);
        chk("model_addr", addr, mpc);
      end
      s_req = req; s_v = iq_valid; s_pc = fpc; s_inst = iq_inst; s_ipc = iq_pc; s_pred = iq_pred;
    end
  end

  task automatic expect_push(input logic [31:0] p, input logic pr, input string n);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (iq_valid) begin
        chk({n, "_pc"}, iq_pc, p);
        chk({n, "_pred"}, {31'b0, iq_pred}, {31'b0, pr});
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no push seen, expected pc %h", n, p);
  endtask

  task automatic expect_req(input logic [31:0] a, input string n);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (iq_valid) begin
        checks++;
        errors++;
        $display("FAIL %s: unexpected push of pc %h while waiting for request %h", n, iq_pc, a);
      end
      if (req) begin
        chk({n, "_addr"}, addr, a);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no request seen, expected addr %h", n, a);
  endtask

  task automatic wait_resp(input string n);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ivalid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no cache response seen", n);
  endtask

  initial begin
    imem[32'h10] = 32'h0100006F;
    imem[32'h20] = 32'h0200006F;
    imem[32'h40] = 32'hFE000EE3;
    imem[32'h44] = 32'h00C0006F;
    repeat (3) cyc();
    rst = 1'b0;
    expect_push(32'h0, 1'b0, "addi_0");
    expect_push(32'h4, 1'b0, "addi_4");
    expect_req(32'h8, "req_8");
    iq_full = 1'b1;
    wait_resp("resp_8");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_no_push", {31'b0, iq_valid}, 0);
    end
    chk("hold_pc", fpc, 32'h8);
    iq_full = 1'b0;
    cyc();
    chk("hold_push_valid", {31'b0, iq_valid}, 1);
    chk("hold_push_pc", iq_pc, 32'h8);
    cyc();
    chk("hold_single_push", {31'b0, iq_valid}, 0);
    expect_req(32'hC, "req_c");
    expect_push(32'hC, 1'b0, "addi_c");
    expect_push(32'h10, 1'b1, "jal_10");
    chk("jal_10_inst", iq_inst, 32'h0100006F);
    expect_req(32'h20, "jal_target");
    bp_pred = 1'b1;
    expect_push(32'h20, 1'b1, "jal_20");
    expect_push(32'h40, 1'b1, "beq_taken");
    expect_req(32'h3C, "beq_taken_target");
    expect_push(32'h3C, 1'b0, "addi_3c");
    bp_pred = 1'b0;
    expect_push(32'h40, 1'b0, "beq_not_taken");
    expect_req(32'h44, "beq_fallthrough");
    expect_push(32'h44, 1'b1, "jal_44");
    expect_req(32'h50, "req_50");
    flush = 1'b1;
    redirect = 32'h100;
    cyc();
    flush = 1'b0;
    chk("flush_pc", fpc, 32'h100);
    chk("flush_req_low", {31'b0, req}, 0);
    expect_req(32'h100, "drop_then_redirect");
    wait_resp("resp_100");
    flush = 1'b1;
    redirect = 32'h200;
    cyc();
    flush = 1'b0;
    chk("coinc_no_push", {31'b0, iq_valid}, 0);
    expect_req(32'h200, "coinc_redirect");
    cyc();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rdy0_req", {31'b0, req}, 1);
      chk("rdy0_pc", fpc, 32'h200);
      chk("rdy0_no_push", {31'b0, iq_valid}, 0);
    end
    rdy = 1'b1;
    expect_push(32'h200, 1'b0, "after_rdy");
    expect_req(32'h204, "req_204");
    iq_full = 1'b1;
    wait_resp("resp_204");
    cyc();
    flush = 1'b1;
    redirect = 32'h300;
    iq_full = 1'b0;
    cyc();
    flush = 1'b0;
    chk("hold_flush_no_push", {31'b0, iq_valid}, 0);
    expect_req(32'h300, "hold_flush_redirect");
    rst = 1'b1;
    cyc();
    chk("midreq_rst_req", {31'b0, req}, 0);
    chk("midreq_rst_pc", fpc, 32'h0);
    rst = 1'b0;
    expect_push(32'h0, 1'b0, "post_rst");
    repeat (4) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
